// File: rtl/nn_pkg.sv
// Shared types and the saturation helper for the sequential dense layer.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_HSIG   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_sel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Wide working width for post-processing; large enough for any
  // shifted accumulator plus bias at the supported data widths.
  localparam int SAT_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_to_w(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      sat_to_w = hi;
    end else if (v < lo) begin
      sat_to_w = lo;
    end else begin
      sat_to_w = v;
    end
  endfunction

endpackage

// File: rtl/neuron_postproc.sv
// One lane of post-processing: rescale the accumulator, add bias,
// saturate to z, then apply the selected activation and saturate to a.
module neuron_postproc
  import nn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int ACC_W  = 35
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] bias,
  input  logic [1:0]        act_sel,
  output logic [DATA_W-1:0] z,
  output logic [DATA_W-1:0] a
);

  localparam int unsigned DW = DATA_W;
  localparam logic signed [SAT_W-1:0] ONE  = 64'sd1 <<< FRAC_W;
  localparam logic signed [SAT_W-1:0] HALF = 64'sd1 <<< (FRAC_W - 1);

  logic signed [SAT_W-1:0] acc_ext_s;
  logic signed [SAT_W-1:0] bias_ext_s;
  logic signed [SAT_W-1:0] sum_s;
  logic signed [SAT_W-1:0] z_full_s;
  logic signed [SAT_W-1:0] act_v_s;
  logic signed [SAT_W-1:0] hsig_s;
  logic signed [SAT_W-1:0] a_full_s;

  // Floor-shift, bias add, saturation and activation for this lane.
  always_comb begin
    acc_ext_s  = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
    bias_ext_s = {{(SAT_W-DATA_W){bias[DATA_W-1]}}, bias};
    sum_s      = (acc_ext_s >>> FRAC_W) + bias_ext_s;
    z_full_s   = sat_to_w(sum_s, DW);
    hsig_s     = (z_full_s >>> 2) + HALF;
    case (act_sel_t'(act_sel))
      ACT_LINEAR: act_v_s = z_full_s;
      ACT_RELU: begin
        if (z_full_s < 64'sd0) begin
          act_v_s = 64'sd0;
        end else begin
          act_v_s = z_full_s;
        end
      end
      ACT_HSIG: begin
        if (hsig_s < 64'sd0) begin
          act_v_s = 64'sd0;
        end else if (hsig_s > ONE) begin
          act_v_s = ONE;
        end else begin
          act_v_s = hsig_s;
        end
      end
      ACT_LEAKY: begin
        if (z_full_s < 64'sd0) begin
          act_v_s = z_full_s >>> 3;
        end else begin
          act_v_s = z_full_s;
        end
      end
      default: act_v_s = z_full_s;
    endcase
    a_full_s = sat_to_w(act_v_s, DW);
    z        = z_full_s[DATA_W-1:0];
    a        = a_full_s[DATA_W-1:0];
  end

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed dense layer: P MAC lanes walk G = ceil(M/P) neuron
// groups, N columns each, then finalise z/a for the group in one FIN cycle.
module neuron_layer_seq
  import nn_pkg::*;
#(
  parameter int M      = 5,
  parameter int N      = 3,
  parameter int P      = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              act_sel,
  input  logic [M*N*DATA_W-1:0]   W,
  input  logic [N*DATA_W-1:0]     x,
  input  logic [M*DATA_W-1:0]     b,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [M*DATA_W-1:0]     z,
  output logic [M*DATA_W-1:0]     a
);

  localparam int G     = (M + P - 1) / P;
  localparam int ACC_W = 2 * DATA_W + $clog2(N) + 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  state_t state_q, state_d;
  act_sel_t act_q, act_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [CW-1:0] col_q, col_d;
  logic done_q, done_d;
  logic signed [DATA_W-1:0] w_q [M][N];
  logic signed [DATA_W-1:0] w_d [M][N];
  logic signed [DATA_W-1:0] x_q [N];
  logic signed [DATA_W-1:0] x_d [N];
  logic signed [DATA_W-1:0] b_q [M];
  logic signed [DATA_W-1:0] b_d [M];
  logic signed [DATA_W-1:0] z_q [M];
  logic signed [DATA_W-1:0] z_d [M];
  logic signed [DATA_W-1:0] a_q [M];
  logic signed [DATA_W-1:0] a_d [M];
  logic [ACC_W-1:0] acc_q [P];
  logic [ACC_W-1:0] acc_d [P];

  int                  lane_n_s      [P];
  logic                lane_active_s [P];
  logic [DATA_W-1:0]   lane_bias_s   [P];
  logic [DATA_W-1:0]   lane_z_s      [P];
  logic [DATA_W-1:0]   lane_a_s      [P];
  logic signed [2*DATA_W-1:0] prod_s;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one MAC pass per column, one FIN per group.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (col_q == CW'(N - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_MAC;
        end
      end
      S_FIN: begin
        if (grp_q == GW'(G - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status and flattened result outputs, all taken from registers.
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q == S_MAC) || (state_q == S_FIN);
    done  = done_q;
    z     = '0;
    a     = '0;
    for (int m = 0; m < M; m++) begin
      z[m*DATA_W +: DATA_W] = z_q[m];
      a[m*DATA_W +: DATA_W] = a_q[m];
    end
  end

  // Map each lane onto its neuron in the current group; idle lanes see zero bias.
  always_comb begin
    for (int l = 0; l < P; l++) begin
      lane_n_s[l]      = int'(grp_q) * P + l;
      lane_active_s[l] = (lane_n_s[l] < M);
      if (lane_active_s[l]) begin
        lane_bias_s[l] = b_q[lane_n_s[l]];
      end else begin
        lane_bias_s[l] = '0;
      end
    end
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    neuron_postproc #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_postproc (
      .acc     (acc_q[l]),
      .bias    (lane_bias_s[l]),
      .act_sel (act_q),
      .z       (lane_z_s[l]),
      .a       (lane_a_s[l])
    );
  end

  // Datapath next values: capture on accept, accumulate in MAC, write back in FIN.
  always_comb begin
    act_d  = act_q;
    grp_d  = grp_q;
    col_d  = col_q;
    done_d = 1'b0;
    w_d    = w_q;
    x_d    = x_q;
    b_d    = b_q;
    z_d    = z_q;
    a_d    = a_q;
    acc_d  = acc_q;
    prod_s = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          act_d = act_sel_t'(act_sel);
          grp_d = '0;
          col_d = '0;
          for (int m = 0; m < M; m++) begin
            b_d[m] = b[m*DATA_W +: DATA_W];
            for (int n = 0; n < N; n++) begin
              w_d[m][n] = W[(m*N+n)*DATA_W +: DATA_W];
            end
          end
          for (int n = 0; n < N; n++) begin
            x_d[n] = x[n*DATA_W +: DATA_W];
          end
          for (int l = 0; l < P; l++) begin
            acc_d[l] = '0;
          end
        end else begin
          act_d = act_q;
        end
      end
      S_MAC: begin
        for (int l = 0; l < P; l++) begin
          if (lane_active_s[l]) begin
            prod_s   = w_q[lane_n_s[l]][col_q] * x_q[col_q];
            acc_d[l] = acc_q[l] + {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
          end else begin
            acc_d[l] = acc_q[l];
          end
        end
        col_d = col_q + CW'(1);
      end
      S_FIN: begin
        for (int l = 0; l < P; l++) begin
          if (lane_active_s[l]) begin
            z_d[lane_n_s[l]] = lane_z_s[l];
            a_d[lane_n_s[l]] = lane_a_s[l];
          end else begin
            acc_d[l] = '0;
          end
          acc_d[l] = '0;
        end
        col_d = '0;
        if (grp_q == GW'(G - 1)) begin
          grp_d  = '0;
          done_d = 1'b1;
        end else begin
          grp_d  = grp_q + GW'(1);
        end
      end
      default: begin
        grp_d = '0;
        col_d = '0;
      end
    endcase
  end

  // Datapath registers; reset clears operands, accumulators and results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q  <= ACT_LINEAR;
      grp_q  <= '0;
      col_q  <= '0;
      done_q <= 1'b0;
      for (int m = 0; m < M; m++) begin
        b_q[m] <= '0;
        z_q[m] <= '0;
        a_q[m] <= '0;
        for (int n = 0; n < N; n++) begin
          w_q[m][n] <= '0;
        end
      end
      for (int n = 0; n < N; n++) begin
        x_q[n] <= '0;
      end
      for (int l = 0; l < P; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      act_q  <= act_d;
      grp_q  <= grp_d;
      col_q  <= col_d;
      done_q <= done_d;
      w_q    <= w_d;
      x_q    <= x_d;
      b_q    <= b_d;
      z_q    <= z_d;
      a_q    <= a_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed and model-based bench for neuron_layer_seq at M=5, N=3, Q4.12.
module tb_neuron_layer_seq;

  localparam int M  = 5;
  localparam int N  = 3;
  localparam int DW = 16;

  logic clk;
  logic reset;
  logic start1, start2, start5;
  logic [1:0] act_sel;
  logic [M*N*DW-1:0] w_v;
  logic [N*DW-1:0]   x_v;
  logic [M*DW-1:0]   b_v;
  logic ready1, busy1, done1, ready2, busy2, done2, ready5, busy5, done5;
  logic [M*DW-1:0] z1, a1, z2, a2, z5, a5;

  int n_chk;
  int n_pass;

  neuron_layer_seq #(.M(M), .N(N), .P(2), .DATA_W(DW), .FRAC_W(12)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .act_sel(act_sel),
    .W(w_v), .x(x_v), .b(b_v), .ready(ready2), .busy(busy2), .done(done2),
    .z(z2), .a(a2));

  neuron_layer_seq #(.M(M), .N(N), .P(1), .DATA_W(DW), .FRAC_W(12)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .act_sel(act_sel),
    .W(w_v), .x(x_v), .b(b_v), .ready(ready1), .busy(busy1), .done(done1),
    .z(z1), .a(a1));

  neuron_layer_seq #(.M(M), .N(N), .P(5), .DATA_W(DW), .FRAC_W(12)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .act_sel(act_sel),
    .W(w_v), .x(x_v), .b(b_v), .ready(ready5), .busy(busy5), .done(done5),
    .z(z5), .a(a5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] el(input logic [M*DW-1:0] vec, input int m);
    return vec[m*DW +: DW];
  endfunction

  function automatic logic signed [15:0] ref_sat(input longint v);
    if (v > 64'sd32767) return 16'sh7fff;
    else if (v < -64'sd32768) return 16'sh8000;
    else return 16'(v);
  endfunction

  function automatic logic signed [15:0] ref_act(input int sel, input logic signed [15:0] zz);
    longint zl, t;
    zl = longint'(zz);
    case (sel)
      1: t = (zl < 0) ? 64'sd0 : zl;
      2: begin
        t = (zl >>> 2) + 64'sd2048;
        if (t < 0) t = 0;
        if (t > 4096) t = 4096;
      end
      3: t = (zl < 0) ? (zl >>> 3) : zl;
      default: t = zl;
    endcase
    return ref_sat(t);
  endfunction

  task automatic set_w(input int m, input int n, input int v);
    w_v[(m*N+n)*DW +: DW] = 16'(v);
  endtask

  task automatic basic_vectors();
    w_v = '0; x_v = '0; b_v = '0;
    set_w(0, 0, 4096);
    set_w(4, 1, 4096);
    x_v[0*DW +: DW] = 16'sd8192;
    x_v[1*DW +: DW] = -16'sd4096;
    x_v[2*DW +: DW] = 16'sd2048;
    b_v[0*DW +: DW] = 16'sd1024;
    b_v[4*DW +: DW] = 16'sd100;
  endtask

  // Start one run on dut2 and return the number of edges to done (-1 on timeout).
  task automatic run2(output int lat, output int ready_bad);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = -1;
    ready_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done2) begin
        lat = k;
        break;
      end
      if (ready2 || !busy2) ready_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_chk++; if (ready2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0)
      $display("FAIL reset_status got r=%b b=%b d=%b exp 1 0 0", ready2, busy2, done2); else n_pass++;
    n_chk++; if (z2 !== '0 || a2 !== '0)
      $display("FAIL reset_outputs got z=%h a=%h exp 0", z2, a2); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_relu();
    int lat, rb;
    basic_vectors();
    act_sel = 2'd1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    act_sel = 2'd0;
    lat = -1; rb = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done2) begin lat = k; break; end
      if (ready2 || !busy2) rb++;
    end
    n_chk++; if (lat !== 12) $display("FAIL basic_latency got %0d exp 12", lat); else n_pass++;
    n_chk++; if (rb !== 0) $display("FAIL basic_ready_low got %0d bad cycles exp 0", rb); else n_pass++;
    n_chk++; if (el(z2,0) !== 16'sd9216) $display("FAIL basic_z0 got %0d exp 9216", el(z2,0)); else n_pass++;
    n_chk++; if (el(a2,0) !== 16'sd9216) $display("FAIL basic_a0 got %0d exp 9216", el(a2,0)); else n_pass++;
    n_chk++; if (el(z2,4) !== -16'sd3996) $display("FAIL basic_z4 got %0d exp -3996", el(z2,4)); else n_pass++;
    n_chk++; if (el(a2,4) !== 16'sd0) $display("FAIL basic_a4_relu_captured got %0d exp 0", el(a2,4)); else n_pass++;
    n_chk++; if (el(z2,1) !== 16'sd0) $display("FAIL basic_z1 got %0d exp 0", el(z2,1)); else n_pass++;
    @(negedge clk);
    n_chk++; if (done2 !== 1'b0) $display("FAIL done_one_cycle got %b exp 0", done2); else n_pass++;
  endtask

  task automatic test_saturation();
    int lat, rb;
    for (int m = 0; m < M; m++) begin
      b_v[m*DW +: DW] = 16'sd32767;
      for (int n = 0; n < N; n++) set_w(m, n, 32767);
    end
    for (int n = 0; n < N; n++) x_v[n*DW +: DW] = 16'sd32767;
    act_sel = 2'd1;
    run2(lat, rb);
    n_chk++; if (el(z2,0) !== 16'sd32767 || el(a2,0) !== 16'sd32767)
      $display("FAIL sat_pos got z=%0d a=%0d exp 32767", el(z2,0), el(a2,0)); else n_pass++;
    n_chk++; if (el(z2,4) !== 16'sd32767) $display("FAIL sat_pos_z4 got %0d exp 32767", el(z2,4)); else n_pass++;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) set_w(m, n, -32767);
    run2(lat, rb);
    n_chk++; if (el(z2,0) !== -16'sd32768 || el(a2,0) !== 16'sd0)
      $display("FAIL sat_neg_relu got z=%0d a=%0d exp -32768 0", el(z2,0), el(a2,0)); else n_pass++;
    act_sel = 2'd0;
    run2(lat, rb);
    n_chk++; if (el(a2,3) !== -16'sd32768)
      $display("FAIL sat_neg_linear got %0d exp -32768", el(a2,3)); else n_pass++;
  endtask

  task automatic test_hsig_leaky();
    int lat, rb;
    w_v = '0; x_v = '0;
    for (int m = 0; m < M; m++) set_w(m, 0, 4096);
    x_v[0*DW +: DW] = 16'sd4096;
    b_v[0*DW +: DW] = -16'sd4096;
    b_v[1*DW +: DW] = 16'sd4096;
    b_v[2*DW +: DW] = -16'sd20480;
    b_v[3*DW +: DW] = -16'sd8192;
    b_v[4*DW +: DW] = 16'sd0;
    act_sel = 2'd2;
    run2(lat, rb);
    n_chk++; if (el(z2,1) !== 16'sd8192) $display("FAIL hsig_z1 got %0d exp 8192", el(z2,1)); else n_pass++;
    n_chk++; if (el(a2,0) !== 16'sd2048) $display("FAIL hsig_a0 got %0d exp 2048", el(a2,0)); else n_pass++;
    n_chk++; if (el(a2,1) !== 16'sd4096) $display("FAIL hsig_a1 got %0d exp 4096", el(a2,1)); else n_pass++;
    n_chk++; if (el(a2,2) !== 16'sd0) $display("FAIL hsig_a2 got %0d exp 0", el(a2,2)); else n_pass++;
    n_chk++; if (el(a2,3) !== 16'sd1024) $display("FAIL hsig_a3 got %0d exp 1024", el(a2,3)); else n_pass++;
    act_sel = 2'd3;
    run2(lat, rb);
    n_chk++; if (el(a2,3) !== -16'sd512) $display("FAIL leaky_a3 got %0d exp -512", el(a2,3)); else n_pass++;
    n_chk++; if (el(a2,1) !== 16'sd8192) $display("FAIL leaky_a1 got %0d exp 8192", el(a2,1)); else n_pass++;
  endtask

  task automatic test_busy_start_ignored();
    int dones, first;
    basic_vectors();
    act_sel = 2'd1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    dones = 0; first = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 5) start2 = 1'b1;
      if (k == 6) start2 = 1'b0;
      if (done2) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    n_chk++; if (dones !== 1 || first !== 12)
      $display("FAIL busy_start_ignored got %0d dones first %0d exp 1 at 12", dones, first); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    basic_vectors();
    act_sel = 2'd1;
    start2 = 1'b1;
    @(negedge clk);
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (d1 > 0 && k == d1 + 1) start2 = 1'b0;
      if (done2) begin
        if (d1 < 0) begin
          d1 = k;
          n_chk++; if (el(z2,0) !== 16'sd9216)
            $display("FAIL b2b_first_z0 got %0d exp 9216", el(z2,0)); else n_pass++;
          x_v[0*DW +: DW] = 16'sd4096;
        end else begin
          d2 = k;
          break;
        end
      end
    end
    start2 = 1'b0;
    n_chk++; if (d1 !== 12 || d2 !== 25)
      $display("FAIL b2b_timing got %0d,%0d exp 12,25", d1, d2); else n_pass++;
    n_chk++; if (el(z2,0) !== 16'sd5120 || el(z2,4) !== -16'sd3996)
      $display("FAIL b2b_second got z0=%0d z4=%0d exp 5120 -3996", el(z2,0), el(z2,4)); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, rb, dones;
    basic_vectors();
    act_sel = 2'd0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if (ready2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0)
      $display("FAIL midreset_status got r=%b b=%b d=%b exp 1 0 0", ready2, busy2, done2); else n_pass++;
    n_chk++; if (z2 !== '0 || a2 !== '0)
      $display("FAIL midreset_outputs got z=%h a=%h exp 0", z2, a2); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done2) dones++;
    end
    n_chk++; if (dones !== 0) $display("FAIL midreset_no_done got %0d exp 0", dones); else n_pass++;
    run2(lat, rb);
    n_chk++; if (lat !== 12 || el(z2,0) !== 16'sd9216)
      $display("FAIL midreset_rerun got lat=%0d z0=%0d exp 12 9216", lat, el(z2,0)); else n_pass++;
  endtask

  task automatic test_random();
    logic [M*DW-1:0] ez, ea;
    logic signed [15:0] t, ww, xx, zz;
    longint acc;
    int sel;
    bit s1, s2, s5;
    for (int i = 0; i < 200; i++) begin
      for (int m = 0; m < M; m++) begin
        for (int n = 0; n < N; n++) begin
          t = 16'($urandom);
          w_v[(m*N+n)*DW +: DW] = t >>> $urandom_range(0, 4);
        end
        b_v[m*DW +: DW] = 16'($urandom);
      end
      for (int n = 0; n < N; n++) begin
        t = 16'($urandom);
        x_v[n*DW +: DW] = t >>> $urandom_range(0, 4);
      end
      sel = int'($urandom_range(0, 3));
      act_sel = 2'(sel);
      for (int m = 0; m < M; m++) begin
        acc = 0;
        for (int n = 0; n < N; n++) begin
          ww = w_v[(m*N+n)*DW +: DW];
          xx = x_v[n*DW +: DW];
          acc = acc + longint'(ww) * longint'(xx);
        end
        t = b_v[m*DW +: DW];
        zz = ref_sat((acc >>> 12) + longint'(t));
        ez[m*DW +: DW] = zz;
        ea[m*DW +: DW] = ref_act(sel, zz);
      end
      start1 = 1'b1; start2 = 1'b1; start5 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0; start5 = 1'b0;
      s1 = 1'b0; s2 = 1'b0; s5 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done1) s1 = 1'b1;
        if (done2) s2 = 1'b1;
        if (done5) s5 = 1'b1;
        if (s1 && s2 && s5) break;
      end
      n_chk++; if (!s1 || z1 !== ez || a1 !== ea)
        $display("FAIL rand_p1 #%0d done=%b got z=%h a=%h exp z=%h a=%h", i, s1, z1, a1, ez, ea); else n_pass++;
      n_chk++; if (!s2 || z2 !== ez || a2 !== ea)
        $display("FAIL rand_p2 #%0d done=%b got z=%h a=%h exp z=%h a=%h", i, s2, z2, a2, ez, ea); else n_pass++;
      n_chk++; if (!s5 || z5 !== ez || a5 !== ea)
        $display("FAIL rand_p5 #%0d done=%b got z=%h a=%h exp z=%h a=%h", i, s5, z5, a5, ez, ea); else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    start1 = 1'b0; start2 = 1'b0; start5 = 1'b0;
    act_sel = 2'd0;
    w_v = '0; x_v = '0; b_v = '0;
    test_reset();
    test_basic_relu();
    test_saturation();
    test_hsig_leaky();
    test_busy_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
